// File: rtl/clk_phase_pkg.sv
// clk_phase_pkg: shared state encoding and phase index constants for clk_phase_sequencer
// Optional feature macro: CLK_PHASE_STEP_EN adds the STEP state.
package clk_phase_pkg;
  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_WB     = 3;
  localparam int PH_NUM    = 4;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTING
`ifdef CLK_PHASE_STEP_EN
    , STEP
`endif
  } state_e;
endpackage

// File: rtl/ce_divider.sv
// ce_divider: programmable clock-enable divider, one tick every div_sel+1 cycles while run is high
// Ports: clk, reset (async active-low), run (count enable), load (latch div_sel, clear count),
//        div_sel (divide ratio), tick (one-cycle enable).
module ce_divider
  import clk_phase_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div_sel,
  output logic             tick
);
  logic [DIV_W-1:0] div_cnt_q, div_q;
  assign tick = run && (div_cnt_q == div_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_cnt_q <= '0;
      div_q     <= '0;
    end else if (load) begin
      div_cnt_q <= '0;
      div_q     <= div_sel;
    end else if (run) begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
    end
endmodule

// File: rtl/clk_phase_sequencer.sv
// clk_phase_sequencer: sequences fetch/decode/execute/writeback clock enables at a divided rate
// Ports: clk, reset (async active-low), start, halt, step (only with CLK_PHASE_STEP_EN),
//        div_sel (divide ratio), phase_en (one-hot enables), instr_done, busy, instr_cnt.
// Optional feature macro: CLK_PHASE_STEP_EN.
module clk_phase_sequencer
  import clk_phase_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
`ifdef CLK_PHASE_STEP_EN
  input  logic              step,
`endif
  input  logic [DIV_W-1:0]  div_sel,
  output logic [PH_NUM-1:0] phase_en,
  output logic              instr_done,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_cnt
);
  state_e           state_q, state_d;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick, load;
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef CLK_PHASE_STEP_EN
      IDLE:    state_d = start ? RUN : step ? STEP : IDLE;
`else
      IDLE:    state_d = start ? RUN : IDLE;
`endif
      RUN:     state_d = halt ? (instr_done ? IDLE : HALTING) : RUN;
      default: state_d = instr_done ? IDLE : state_q;
    endcase
  end
  assign load       = (state_q == IDLE) && (state_d != IDLE);
  assign busy       = state_q != IDLE;
  assign phase_en   = tick ? PH_NUM'(1) << ptr_q : '0;
  assign instr_done = tick && (ptr_q == 2'(PH_WB));
  assign instr_cnt  = cnt_q;
  ce_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .reset   (reset),
    .run     (busy),
    .load    (load),
    .div_sel (div_sel),
    .tick    (tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= load ? '0 : tick ? ptr_q + 1'b1 : ptr_q;
      cnt_q   <= cnt_q + CNT_W'(instr_done);
    end
endmodule

// File: tb/tb_clk_phase_sequencer.sv
// tb_clk_phase_sequencer: randomized scoreboard bench against an arithmetic tick-schedule model
module tb_clk_phase_sequencer;
  localparam int DIV_W = 4;
  localparam int CNT_W = 4;
  logic clk = 0, reset = 0, start = 0, halt = 0;
`ifdef CLK_PHASE_STEP_EN
  logic step = 0;
`endif
  logic [DIV_W-1:0] div_sel = '0;
  logic [3:0] phase_en;
  logic instr_done, busy;
  logic [CNT_W-1:0] instr_cnt;
  int tests = 0, fails = 0, cyc_n = 0;
  bit m_busy;
  int m_mode, m_p, m_c, m_cnt;
  typedef struct {int stamp; logic [3:0] pe; logic done;} ev_t;
  ev_t q[$];
  ev_t mon_e;
  always #5 clk = ~clk;
  clk_phase_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
`ifdef CLK_PHASE_STEP_EN
    .step(step),
`endif
    .div_sel(div_sel), .phase_en(phase_en), .instr_done(instr_done),
    .busy(busy), .instr_cnt(instr_cnt)
  );
  function automatic bit m_tick();
    return m_busy && ((m_c + 1) % m_p == 0);
  endfunction
  function automatic int m_ph();
    return ((m_c + 1) / m_p - 1) % 4;
  endfunction
  task automatic m_clear();
    m_busy = 0; m_mode = 0; m_p = 1; m_c = 0; m_cnt = 0;
  endtask
  task automatic chk(string n, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", n, cyc_n, got, exp);
    end
  endtask
  task automatic begin_busy(int mode);
    m_busy = 1; m_mode = mode; m_p = int'(div_sel) + 1; m_c = 0;
  endtask
  task automatic cyc();
    bit d;
    ev_t e;
    d = m_tick() && m_ph() == 3;
    @(posedge clk);
    cyc_n++;
    if (!reset) m_clear();
    else if (!m_busy) begin
      if (start) begin_busy(0);
`ifdef CLK_PHASE_STEP_EN
      else if (step) begin_busy(2);
`endif
    end else begin
      if (d) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_mode == 0 && halt) begin
        if (d) m_busy = 0; else m_mode = 1;
      end else if (m_mode != 0 && d) m_busy = 0;
      m_c++;
    end
    if (m_tick()) begin
      e.stamp = cyc_n; e.pe = 4'(1 << m_ph()); e.done = (m_ph() == 3);
      q.push_back(e);
    end
    #1;
  endtask
  task automatic do_reset();
    start = 0; halt = 0;
`ifdef CLK_PHASE_STEP_EN
    step = 0;
`endif
    #2 reset = 0;
    m_clear();
    q.delete();
    cyc();
    reset = 1;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_phase_en", phase_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_instr_cnt", instr_cnt, 0);
    end else begin
      while (q.size() > 0 && q[0].stamp < cyc_n) begin
        mon_e = q.pop_front();
        tests++; fails++;
        $display("FAIL missing_tick cycle=%0d got=none exp_pe=%b at cycle %0d", cyc_n, mon_e.pe, mon_e.stamp);
      end
      if (phase_en != 0 || instr_done) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_tick cycle=%0d got_pe=%b done=%b exp=none", cyc_n, phase_en, instr_done);
        end else begin
          mon_e = q.pop_front();
          chk("tick_cycle", cyc_n, mon_e.stamp);
          chk("phase_en", phase_en, mon_e.pe);
          chk("instr_done", instr_done, mon_e.done);
        end
      end
      chk("busy", busy, m_busy);
      chk("instr_cnt", instr_cnt, m_cnt);
    end
  end
  // how: 0 start, 1 step, 2 start and step together
  task automatic run_ep(int ds, int how, int halt_after, int rst_at);
    int k = 0;
    div_sel = DIV_W'(ds);
    start = (how != 1);
`ifdef CLK_PHASE_STEP_EN
    step = (how != 0);
`endif
    cyc();
    start = 0;
`ifdef CLK_PHASE_STEP_EN
    step = 0;
`endif
    while (m_busy && k < 3000) begin
      if (k == rst_at) begin
        do_reset();
        break;
      end
      halt = (k >= halt_after);
      start = ($urandom_range(0, 3) == 0);
      div_sel = DIV_W'($urandom);
`ifdef CLK_PHASE_STEP_EN
      step = ($urandom_range(0, 3) == 0);
`endif
      cyc();
      k++;
    end
    if (k >= 3000) begin
      tests++; fails++;
      $display("FAIL timeout cycle=%0d got=busy exp=idle", cyc_n);
      do_reset();
    end
    start = 0; halt = 0;
`ifdef CLK_PHASE_STEP_EN
    step = 0;
`endif
  endtask
  initial begin
    m_clear();
    repeat (2) cyc();
    reset = 1;
    cyc();
    run_ep(0, 0, 0, -1);
    run_ep(7, 0, 64, -1);
    run_ep(7, 0, 50, -1);
    run_ep(0, 0, 1, -1);
    run_ep(3, 0, 9, -1);
    run_ep(1, 0, 100, 5);
    repeat (3) cyc();
    run_ep(2, 1, 0, -1);
    run_ep(2, 2, 20, -1);
    run_ep(15, 0, 70, -1);
    run_ep(0, 0, 70, -1);
    for (int i = 0; i < 60; i++) begin
      int ds = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      int ha = $urandom_range(0, 12 * (ds + 1));
      int ra = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8 * (ds + 1)) : -1;
      run_ep(ds, $urandom_range(0, 2), ha, ra);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) cyc();
    end
    repeat (3) cyc();
    chk("leftover_events", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clk_phase_sequencer.md
# clk_phase_sequencer

Synchronous replacement for the ripple clock-divider chain: a single-clock controller that sequences the processor's four instruction phases (fetch, decode, execute, writeback) by issuing one-cycle clock-enable pulses at a programmable divided rate. It sits between the board clock and the pipeline registers. It owns start/halt control, so the datapath runs on `clk` with enables instead of derived clocks.

## Interface
- `DIV_W`, 4: width of the divide-ratio field.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low clears all state immediately.
- `start`  in  1  request to begin continuous execution; sampled only in IDLE.
- `halt`  in  1  request to stop at the next instruction boundary; sampled in RUN.
- `step`  in  1  single-instruction request, sampled only in IDLE. Present only with `CLK_PHASE_STEP_EN`.
- `div_sel`  in  DIV_W  divide ratio: one phase tick every `div_sel`+1 cycles. Latched into `div_q` on leaving IDLE.
- `phase_en`  out  4  one-hot phase enable, high for one cycle per tick: [0] fetch, [1] decode, [2] execute, [3] writeback.
- `instr_done`  out  1  high in the same cycle as `phase_en[3]`.
- `busy`  out  1  high whenever state is not IDLE.
- `instr_cnt`  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

## Operation
- Registers:
  - `state`: IDLE, RUN, HALTING, STEP.
  - `div_cnt` (DIV_W).
  - `div_q` (DIV_W).
  - `ptr`: 2-bit phase pointer.
  - `instr_cnt`.
- Tick: `tick` = (state ≠ IDLE) and (`div_cnt` == `div_q`).
  - When `tick` is high, `div_cnt` clears to 0; otherwise it increments.
  - On a tick, `ptr` advances 0→1→2→3→0.
- Outputs:
  - `phase_en` = `tick` ? onehot(`ptr`) : 0, decoded from registers only.
  - `instr_done` = `tick` and `ptr`==3.
- Transitions:
  - IDLE, `start`=1 → RUN. On this transition `div_q` ← `div_sel`, `div_cnt` ← 0, `ptr` ← 0.
  - IDLE, `step`=1, `start`=0 → STEP, with the same loads. `start` has priority over `step`.
  - RUN, `halt`=1 and not `instr_done` → HALTING.
  - RUN, `halt`=1 and `instr_done` → IDLE. The current writeback completes.
  - HALTING and STEP, `instr_done` → IDLE.
- Ignored inputs:
  - `start` and `step` outside IDLE.
  - `halt` in IDLE, HALTING and STEP.
  - `div_sel` outside the IDLE exit cycle.
- `instr_cnt` increments at the clock edge that ends each `instr_done` cycle.

## Timing
- Reset values: state IDLE, `div_cnt`=0, `div_q`=0, `ptr`=0, `instr_cnt`=0. Hence `phase_en`=0, `instr_done`=0, `busy`=0.
- `start` sampled at edge E → `busy` high from E.
  - First `phase_en[0]` is in the (`div_sel`+1)-th cycle after E.
  - With `div_sel`=0 this is the cycle immediately after E.
- Instruction period is 4×(`div_sel`+1) cycles; ticks are strictly periodic while busy.
- After the final `instr_done` cycle, `busy` falls at the next edge.
- A new `start` is accepted one cycle after return to IDLE. There is no dead time beyond that.
- Reset asserted mid-instruction: all outputs clear asynchronously. The partial instruction is not counted.
- `div_sel` at maximum (2^DIV_W−1) gives one tick per 2^DIV_W cycles. No overflow occurs, because `div_cnt` never exceeds `div_q`.

## Configuration
- `CLK_PHASE_STEP_EN` defined: the `step` port and the STEP state exist, behaving as above.
- `CLK_PHASE_STEP_EN` undefined: no `step` port and no STEP state. The state encoding has 3 values, and IDLE exits only on `start`.

## Structure
- Package `clk_phase_pkg` contains:
  - the state enum;
  - phase index constants `PH_FETCH`=0, `PH_DECODE`=1, `PH_EXEC`=2, `PH_WB`=3;
  - `PH_NUM`=4.
- Sub-module `ce_divider`: the `div_cnt`/`div_q` counter producing `tick`.
  - Inputs: `clk`, `reset`, `run`, `load`, `div_sel`.
  - Output: `tick`.
- FSM, `ptr` and `instr_cnt` stay in the top module.

## Test plan
- Reset, `div_sel`=0, pulse `start` → `phase_en` = 0001, 0010, 0100, 1000 on four consecutive cycles. `instr_done` is high with 1000, and `instr_cnt`=1 after.
- `div_sel`=7, run 2 instructions then `halt` → enables every 8 cycles, 32 cycles per instruction. `instr_cnt`=2 or 3 depending on the halt point, never a partial instruction.
- `halt` asserted during the decode tick → execute and writeback still issue. `busy` falls the cycle after `phase_en[3]`, and `instr_cnt` gains exactly 1.
- Change `div_sel` 0→3 mid-RUN → tick period stays 1 until halt and restart. It becomes 4 after the next `start`.
- Drive `reset` low for one cycle during execute → `phase_en`, `busy` and `instr_cnt` are 0 immediately. No enable appears until a new `start`.
- With `CLK_PHASE_STEP_EN`, `step` and `start` are exercised as follows:
  - `step` pulse: exactly four enables, then IDLE.
  - `step` and `start` together: RUN.
- With `CNT_W`=4, run 17 instructions → `instr_cnt`=1.
